im_loader: RTL

- Program-load engine for the instruction memory (IM); the write-side counterpart of the CPU's fetch-only IM interface.
- Accepts a valid/ready stream of 32-bit instruction words and writes them sequentially into IM from address 0, holding the CPU in reset while it does so.
- Reads the whole image back and checks it against a running checksum, then releases the CPU.
- Replaces bench-side memory preloading, so a program load becomes a bus-accurate, cycle-timed operation.

---
 rtl/im_loader_pkg.sv | 16 +
 rtl/im_loader_csum.sv | 23 ++
 rtl/im_loader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/im_loader_pkg.sv
// rtl/im_loader_pkg.sv - shared types and defaults for the IM program-load engine
package im_loader_pkg;

   localparam int DATA_SIZE       = 32;
   localparam int MEM_SIZE        = 10;
   localparam int IM_READ_LATENCY = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_VERIFY,
      ST_DONE,
      ST_ERROR
   } state_t;

endpackage

// File: rtl/im_loader_csum.sv
// rtl/im_loader_csum.sv - modular accumulator with clear and enable
module im_loader_csum
   import im_loader_pkg::*;
#(
   parameter int Width = DATA_SIZE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [Width-1:0] din,
   output logic [Width-1:0] sum
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         sum <= '0;
      end else if (en) begin
         sum <= sum + din;
      end
   end

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - streams a program image into IM, verifies it by checksum, then releases the CPU
module im_loader
   import im_loader_pkg::*;
#(
   parameter int DataSize = DATA_SIZE,
   parameter int MemSize  = MEM_SIZE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DataSize-1:0] in_data,
   input  logic                in_last,
   output logic [MemSize-1:0]  im_address,
   output logic                im_enable,
   output logic                im_fetch,
   output logic                im_write,
   output logic [DataSize-1:0] im_din,
   input  logic [DataSize-1:0] im_dout,
   output logic                cpu_reset,
   output logic                done,
   output logic                error,
   output logic [MemSize:0]    word_cnt
);

   typedef logic [IM_READ_LATENCY-1:0] pipe_t;
   localparam pipe_t PIPE_TAIL = pipe_t'(1) << (IM_READ_LATENCY - 1);

   state_t              state;
   state_t              state_next;
   logic [MemSize:0]    rd_idx;
   pipe_t               rd_pipe;
   logic [DataSize-1:0] checksum;
   logic [DataSize-1:0] rb_sum;
   logic                full;
   logic                start_ok;
   logic                resp_valid;
   logic                last_resp;
   logic                sum_match;

   assign full       = word_cnt[MemSize];
   assign start_ok   = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
   assign resp_valid = rd_pipe[IM_READ_LATENCY-1];
   // The final response is the only one still in flight once every index has been fetched.
   assign last_resp  = resp_valid && (rd_idx == word_cnt) && (rd_pipe == PIPE_TAIL);
   assign sum_match  = (rb_sum + im_dout) == checksum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            if (in_valid && !full && in_last) begin
               state_next = ST_VERIFY;
            end else if (in_valid && full) begin
               state_next = ST_ERROR;
            end
         end
         ST_VERIFY: begin
            if (last_resp) state_next = sum_match ? ST_DONE : ST_ERROR;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready   = 1'b0;
      im_enable  = 1'b0;
      im_fetch   = 1'b0;
      im_write   = 1'b0;
      im_address = '0;
      im_din     = '0;
      done       = 1'b0;
      error      = 1'b0;
      cpu_reset  = 1'b1;
      case (state)
         ST_LOAD: begin
            in_ready = !full;
            if (in_valid && !full) begin
               im_enable  = 1'b1;
               im_write   = 1'b1;
               im_address = word_cnt[MemSize-1:0];
               im_din     = in_data;
            end
            if (in_valid && full) error = 1'b1;
         end
         ST_VERIFY: begin
            if (rd_idx < word_cnt) begin
               im_enable  = 1'b1;
               im_fetch   = 1'b1;
               im_address = rd_idx[MemSize-1:0];
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            cpu_reset = 1'b0;
         end
         ST_ERROR: begin
            error = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_cnt <= '0;
         rd_idx   <= '0;
         rd_pipe  <= '0;
      end else begin
         if (start_ok) begin
            word_cnt <= '0;
         end else if (im_write) begin
            word_cnt <= word_cnt + (MemSize+1)'(1);
         end
         if (im_write && in_last) begin
            rd_idx <= '0;
         end else if (im_fetch) begin
            rd_idx <= rd_idx + (MemSize+1)'(1);
         end
         rd_pipe <= (rd_pipe << 1) | pipe_t'(im_fetch);
      end
   end

   im_loader_csum #(.Width(DataSize)) u_wr_csum (
      .clk (clk),
      .rst (rst),
      .clr (start_ok),
      .en  (im_write),
      .din (in_data),
      .sum (checksum)
   );

   im_loader_csum #(.Width(DataSize)) u_rb_csum (
      .clk (clk),
      .rst (rst),
      .clr (im_write && in_last),
      .en  (resp_valid),
      .din (im_dout),
      .sum (rb_sum)
   );

endmodule
